// File: rtl/sqrt_share_ctrl.sv
// Round-robin scheduler sharing one psdsqrt core among NUM_REQ requesters.
// The winner's operand is latched into the core. The core then receives a
// one-cycle start, CORE_CYCLES cycles of computation and a one-cycle stop.
// Its result is captured and returned with a one-hot done tagged to the winner.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   req, xin_bus      per-requester level request and packed operands
//   gnt, done         one-hot single-cycle grant / completion pulses
//   done_id, result   completed requester index and its square root
//   busy              high whenever the scheduler is not idle
//   core_start/stop   control pulses to the core
//   core_xin/sqrt     core operand (registered) and core result
module sqrt_share_ctrl #(
  parameter int unsigned NUM_BITS    = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned CORE_CYCLES = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  xin_bus,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           done,
  output logic [ID_W-1:0]              done_id,
  output logic [NUM_BITS/2-1:0]        result,
  output logic                         core_start,
  output logic                         core_stop,
  output logic [NUM_BITS-1:0]          core_xin,
  input  logic [NUM_BITS/2-1:0]        core_sqrt
);

  localparam int unsigned RES_W = NUM_BITS / 2;
  localparam int unsigned CNT_W = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    STOP    = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [NUM_REQ-1:0]  gnt_d, done_d;
  logic [ID_W-1:0]     done_id_d;
  logic [RES_W-1:0]    result_d;
  logic [NUM_BITS-1:0] core_xin_d;
  logic                core_start_d, core_stop_d, busy_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;

  // Round-robin pick: first set req bit searching upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_q      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      done_id    <= '0;
      result     <= '0;
      core_start <= 1'b0;
      core_stop  <= 1'b0;
      core_xin   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      win_q      <= win_d;
      cnt        <= cnt_d;
      gnt        <= gnt_d;
      done       <= done_d;
      done_id    <= done_id_d;
      result     <= result_d;
      core_start <= core_start_d;
      core_stop  <= core_stop_d;
      core_xin   <= core_xin_d;
      busy       <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win_found) state_d = START;
      START:   state_d = RUN;
      RUN:     if (cnt == '0) state_d = STOP;
      STOP:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers on the next edge,
  // so each pulse is computed one state ahead of the cycle it appears in.
  always_comb begin
    gnt_d        = '0;
    done_d       = '0;
    done_id_d    = done_id;
    result_d     = result;
    core_xin_d   = core_xin;
    core_start_d = 1'b0;
    core_stop_d  = 1'b0;
    busy_d       = (state_d != IDLE);
    win_d        = win_q;
    cnt_d        = cnt;
    rr_ptr_d     = rr_ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          core_xin_d     = xin_bus[win_id*NUM_BITS +: NUM_BITS];
          gnt_d[win_id]  = 1'b1;
          win_d          = win_id;
          core_start_d   = 1'b1;
        end
      end
      START: cnt_d = CNT_W'(CORE_CYCLES - 1);
      RUN: begin
        if (cnt == '0) core_stop_d = 1'b1;
        else           cnt_d = cnt - 1'b1;
      end
      CAPTURE: begin
        result_d      = core_sqrt;
        done_d[win_q] = 1'b1;
        done_id_d     = win_q;
        rr_ptr_d      = ID_W'((32'(win_q) + 1) % NUM_REQ);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Scoreboard bench for sqrt_share_ctrl with a behavioural psdsqrt model.
module tb_sqrt_share_ctrl;

  localparam int unsigned NB = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CC = 16;
  localparam int unsigned RW = NB / 2;

  logic              clock, reset;
  logic [NR-1:0]     req;
  logic [NR*NB-1:0]  xin_bus;
  logic [NR-1:0]     gnt, done;
  logic              busy;
  logic [IW-1:0]     done_id;
  logic [RW-1:0]     result;
  logic              core_start, core_stop;
  logic [NB-1:0]     core_xin;
  logic [RW-1:0]     core_sqrt;

  sqrt_share_ctrl #(.NUM_BITS(NB), .NUM_REQ(NR), .ID_W(IW), .CORE_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .req(req), .xin_bus(xin_bus),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result),
    .core_start(core_start), .core_stop(core_stop), .core_xin(core_xin),
    .core_sqrt(core_sqrt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RW-1:0] res;
  } exp_t;

  int   exp_gnt[$];
  exp_t exp_done[$];
  int   checks = 0;
  int   errors = 0;
  int   gcyc   = 0;
  logic [NR-1:0] sticky;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural core: latches operand on start, presents floor(sqrt) after stop.
  function automatic logic [RW-1:0] isqrt(input logic [NB-1:0] x);
    logic [RW-1:0] r;
    logic [RW-1:0] t;
    r = '0;
    for (int b = RW - 1; b >= 0; b--) begin
      t = r | (RW'(1) << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  logic [NB-1:0] held_x;
  always @(posedge clock) begin
    if (reset) begin
      held_x    <= '0;
      core_sqrt <= '0;
    end else if (core_start) begin
      held_x    <= core_xin;
      core_sqrt <= 16'hDEAD;
    end else if (core_stop) begin
      core_sqrt <= isqrt(held_x);
    end
  end

  // Monitor: pops scoreboard entries on gnt/done and checks pulse timing.
  always @(negedge clock) begin
    if (!reset) begin
      if (gnt != '0) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(gnt), 64'(0));
        else check("gnt_onehot", 64'(gnt), 64'(1) << exp_gnt.pop_front());
        check("start_with_gnt", 64'(core_start), 64'(1));
        check("busy_at_gnt", 64'(busy), 64'(1));
        gcyc = cyc;
      end else if (core_start) begin
        check("start_without_gnt", 64'(core_start), 64'(0));
      end
      if (core_stop) check("stop_cycle", 64'(cyc), 64'(gcyc + int'(CC) + 1));
      if (done != '0) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = exp_done.pop_front();
          check("done_onehot", 64'(done), 64'(1) << e.id);
          check("done_id", 64'(done_id), 64'(e.id));
          check("result", 64'(result), 64'(e.res));
          check("done_cycle", 64'(cyc), 64'(gcyc + int'(CC) + 3));
          check("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  // One cycle: requesters drop req (and their operand) after seeing gnt.
  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < int'(NR); i++) begin
      if (gnt[i] && !sticky[i]) begin
        req[i] = 1'b0;
        xin_bus[i*NB +: NB] = '0;
      end
    end
  endtask

  task automatic issue(input int id, input logic [NB-1:0] x, input logic [RW-1:0] r,
                       input bit expect_done);
    exp_t e;
    req[id] = 1'b1;
    xin_bus[id*NB +: NB] = x;
    exp_gnt.push_back(id);
    if (expect_done) begin
      e.id  = IW'(id);
      e.res = r;
      exp_done.push_back(e);
    end
  endtask

  task automatic wait_gnt(input int id, output int c);
    bit seen;
    seen = 1'b0;
    c = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (gnt[id]) begin
        seen = 1'b1;
        c = cyc;
      end
    end
    if (!seen) check("wait_gnt_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (exp_gnt.size() == 0 && exp_done.size() == 0 && !busy && req == '0) ok = 1'b1;
      else tick();
    end
    if (!ok) check("wait_idle_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int t, c0, c1, c2, c3;
    reset   = 1'b1;
    req     = '0;
    xin_bus = '0;
    sticky  = '0;
    repeat (3) @(negedge clock);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_core_xin", 64'(core_xin), 64'(0));
    check("rst_core_ctl", 64'({core_start, core_stop}), 64'(0));
    reset = 1'b0;
    tick();

    // Simultaneous requests from a fresh rr_ptr: order 0,1,2,3, 20 cycles apart.
    issue(0, 32'h0000_0019, 16'h0005, 1'b1);
    issue(1, 32'h0000_0400, 16'h0020, 1'b1);
    issue(2, 32'h00F4_2400, 16'h0FA0, 1'b1);
    issue(3, 32'h0000_FFFF, 16'h00FF, 1'b1);
    wait_gnt(0, c0);
    wait_gnt(1, c1);
    wait_gnt(2, c2);
    wait_gnt(3, c3);
    check("rr_period_01", 64'(c1 - c0), 64'(CC + 4));
    check("rr_period_12", 64'(c2 - c1), 64'(CC + 4));
    check("rr_period_23", 64'(c3 - c2), 64'(CC + 4));
    wait_idle();

    // Single request with explicit grant latency.
    issue(0, 32'h0000_0090, 16'h000C, 1'b1);
    t = cyc;
    tick();
    check("single_gnt", 64'(gnt), 64'(1));
    check("single_gnt_cycle", 64'(cyc), 64'(t + 1));
    wait_idle();

    // Requester 2 served, then 0 and 1 together: 0 wins after the wrap.
    issue(2, 32'h0000_0064, 16'h000A, 1'b1);
    wait_idle();
    issue(0, 32'h0000_0051, 16'h0009, 1'b1);
    issue(1, 32'h0000_0010, 16'h0004, 1'b1);
    wait_idle();

    // Operand boundaries; 2 before 3 confirms rr_ptr ended at 2.
    issue(2, 32'hFFFF_FFFF, 16'hFFFF, 1'b1);
    issue(3, 32'h0000_0000, 16'h0000, 1'b1);
    wait_idle();
    issue(0, 32'h0000_0001, 16'h0001, 1'b1);
    wait_idle();

    // Reset in the middle of RUN abandons the job; rr_ptr returns to 0.
    issue(3, 32'h0001_0000, 16'h0100, 1'b0);
    wait_gnt(3, c0);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrst_outputs", 64'({gnt, done, core_start, core_stop, busy}), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_core_xin", 64'(core_xin), 64'(0));
    check("midrst_done_id", 64'(done_id), 64'(0));
    reset = 1'b0;
    repeat (30) tick();
    issue(0, 32'h0000_0031, 16'h0007, 1'b1);
    issue(1, 32'h4000_0000, 16'h8000, 1'b1);
    wait_idle();

    // Stuck request: re-granted the cycle after each done, no idle gap.
    sticky[2] = 1'b1;
    issue(2, 32'h0000_00A9, 16'h000D, 1'b1);
    issue(2, 32'h0000_00A9, 16'h000D, 1'b1);
    issue(2, 32'h0000_00A9, 16'h000D, 1'b1);
    wait_gnt(2, c0);
    wait_gnt(2, c1);
    wait_gnt(2, c2);
    sticky[2] = 1'b0;
    req[2] = 1'b0;
    check("stuck_period_a", 64'(c1 - c0), 64'(CC + 4));
    check("stuck_period_b", 64'(c2 - c1), 64'(CC + 4));
    wait_idle();

    repeat (5) tick();
    check("gnt_queue_drained", 64'(exp_gnt.size()), 64'(0));
    check("done_queue_drained", 64'(exp_done.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
